// File: rtl/action_scheduler.sv
// Button-pulse action scheduler: arbitrates debounced button pulses into a 4-entry FIFO
// and offers each action to the game FSM, then holds and cools down before the next one.
module action_scheduler #(
  parameter int unsigned HOLD_JUMP  = 24,
  parameter int unsigned HOLD_SLIDE = 16,
  parameter int unsigned COOLDOWN   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  input  logic       btn_slide,
  input  logic       game_active,
  input  logic       act_ready,
  output logic       act_valid,
  output logic [1:0] act_code,
  output logic       busy,
  output logic [2:0] fifo_count,
  output logic       dropped
);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, COOL} state_t;

  localparam logic [1:0] CODE_JUMP  = 2'b10;
  localparam logic [1:0] CODE_SLIDE = 2'b11;
  localparam logic [7:0] JUMP_LD    = 8'(HOLD_JUMP - 1);
  localparam logic [7:0] SLIDE_LD   = 8'(HOLD_SLIDE - 1);
  localparam logic [7:0] COOL_LD    = 8'(COOLDOWN - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [1:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;

  logic       push_req;
  logic       loser;
  logic [1:0] win_code;
  logic       pop;
  logic       full;
  logic       push_ok;

  always_comb begin
    win_code = '0;
    if (btn_jump)       win_code = CODE_JUMP;
    else if (btn_slide) win_code = CODE_SLIDE;
    else if (btn_left)  win_code = 2'b00;
    else if (btn_right) win_code = 2'b01;
    push_req = btn_jump | btn_slide | btn_left | btn_right;
    loser    = (btn_jump  & (btn_slide | btn_left | btn_right)) |
               (btn_slide & (btn_left | btn_right)) |
               (btn_left  & btn_right);
    full     = (fifo_count == 3'd4);
    pop      = (state == IDLE) && (fifo_count != '0) && game_active;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    push_ok  = push_req && (!full || pop);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      act_valid  <= 1'b0;
      act_code   <= '0;
      busy       <= 1'b0;
      dropped    <= 1'b0;
    end else if (!game_active) begin
      state      <= IDLE;
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      act_valid  <= 1'b0;
      busy       <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      dropped <= loser || (push_req && !push_ok);
      if (push_ok) begin
        mem[wr_ptr] <= win_code;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      fifo_count <= fifo_count + 3'(push_ok) - 3'(pop);

      unique case (state)
        IDLE: begin
          if (pop) begin
            act_code  <= mem[rd_ptr];
            act_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (act_ready) begin
            act_valid <= 1'b0;
            if (act_code == CODE_JUMP) begin
              state <= HOLD;
              cnt   <= JUMP_LD;
            end else if (act_code == CODE_SLIDE) begin
              state <= HOLD;
              cnt   <= SLIDE_LD;
            end else begin
              state <= COOL;
              cnt   <= COOL_LD;
            end
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state <= COOL;
            cnt   <= COOL_LD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        COOL: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_action_scheduler.sv
// Directed self-checking bench for action_scheduler with default parameters.
module tb_action_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_left, btn_right, btn_jump, btn_slide;
  logic       game_active, act_ready;
  logic       act_valid;
  logic [1:0] act_code;
  logic       busy;
  logic [2:0] fifo_count;
  logic       dropped;

  int checks = 0;
  int errors = 0;
  logic left_seen;
  logic valid_seen;

  action_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_jump   (btn_jump),
    .btn_slide  (btn_slide),
    .game_active(game_active),
    .act_ready  (act_ready),
    .act_valid  (act_valid),
    .act_code   (act_code),
    .busy       (busy),
    .fifo_count (fifo_count),
    .dropped    (dropped)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy || fifo_count != 0 || act_valid) && n < 500) begin
      if (act_valid && act_code == 2'b00) left_seen = 1'b1;
      tick();
      n++;
    end
    chk(tag, 32'(n < 500), 32'd1);
  endtask

  initial begin
    int n;
    logic [1:0] rec [8];
    int nrec;
    logic injected, inj_now;

    reset = 1'b0; game_active = 1'b1; act_ready = 1'b0;
    btn_left = 0; btn_right = 0; btn_jump = 0; btn_slide = 0;

    // Reset state
    tick(); tick();
    chk("rst_valid", 32'(act_valid), 0);
    chk("rst_code",  32'(act_code), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_drop",  32'(dropped), 0);
    reset = 1'b1;
    tick();

    // Jump with act_ready tied high: latency 2, busy for 1+24+8 cycles
    act_ready = 1'b1;
    btn_jump = 1; tick(); btn_jump = 0;
    chk("j_count_t1", 32'(fifo_count), 1);
    chk("j_valid_t1", 32'(act_valid), 0);
    tick();
    chk("j_valid_t2", 32'(act_valid), 1);
    chk("j_code_t2",  32'(act_code), 2);
    chk("j_busy_t2",  32'(busy), 1);
    chk("j_count_t2", 32'(fifo_count), 0);
    n = 1;
    tick();
    chk("j_valid_hold", 32'(act_valid), 0);
    while (busy && n < 200) begin
      n++;
      tick();
    end
    chk("j_busy_len", 32'(n), 33);
    chk("j_code_kept", 32'(act_code), 2);
    chk("j_idle_valid", 32'(act_valid), 0);

    // Left and jump together: jump wins, one dropped pulse, no left ever issued
    left_seen = 1'b0;
    btn_left = 1; btn_jump = 1; tick(); btn_left = 0; btn_jump = 0;
    chk("arb_drop", 32'(dropped), 1);
    chk("arb_count", 32'(fifo_count), 1);
    tick();
    chk("arb_drop_once", 32'(dropped), 0);
    chk("arb_valid", 32'(act_valid), 1);
    chk("arb_code", 32'(act_code), 2);
    wait_idle("arb_idle_timeout");
    chk("arb_no_left", 32'(left_seen), 0);

    // Slide stalled 10 cycles in ISSUE; HOLD starts on accept
    act_ready = 1'b0;
    btn_slide = 1; tick(); btn_slide = 0;
    tick();
    chk("stall_valid0", 32'(act_valid), 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_valid", 32'(act_valid), 1);
      chk("stall_code", 32'(act_code), 3);
    end
    act_ready = 1'b1;
    tick();
    chk("stall_accept_valid", 32'(act_valid), 0);
    chk("stall_accept_busy", 32'(busy), 1);
    n = 1;
    while (busy && n < 200) begin
      tick();
      if (busy) n++;
    end
    chk("stall_busy_len", 32'(n), 24);

    // Overflow: one popped into ISSUE, four queued, sixth pulse dropped
    act_ready = 1'b0;
    btn_left = 1; tick(); btn_left = 0;
    tick();
    chk("ovf_issue_code", 32'(act_code), 0);
    chk("ovf_count0", 32'(fifo_count), 0);
    btn_right = 1; tick(); btn_right = 0;
    btn_jump  = 1; tick(); btn_jump  = 0;
    btn_slide = 1; tick(); btn_slide = 0;
    chk("ovf_count3", 32'(fifo_count), 3);
    btn_left  = 1; tick(); btn_left  = 0;
    chk("ovf_count4", 32'(fifo_count), 4);
    chk("ovf_nodrop5", 32'(dropped), 0);
    btn_right = 1; tick(); btn_right = 0;
    chk("ovf_drop6", 32'(dropped), 1);
    chk("ovf_count_full", 32'(fifo_count), 4);
    tick();
    chk("ovf_drop_clear", 32'(dropped), 0);

    // Drain in FIFO order; push into the full FIFO on the cycle its head pops
    act_ready = 1'b1;
    nrec = 0;
    injected = 1'b0;
    n = 0;
    while (nrec < 5 && n < 600) begin
      inj_now = 1'b0;
      if (!busy && !injected) begin
        chk("pop_full_pre", 32'(fifo_count), 4);
        btn_right = 1;
        injected = 1'b1;
        inj_now = 1'b1;
      end
      tick();
      btn_right = 0;
      n++;
      if (inj_now) begin
        chk("pop_full_count", 32'(fifo_count), 4);
        chk("pop_full_nodrop", 32'(dropped), 0);
      end
      if (act_valid) begin
        rec[nrec] = act_code;
        nrec++;
      end
    end
    chk("order_n", 32'(nrec), 5);
    chk("order_0", 32'(rec[0]), 1);
    chk("order_1", 32'(rec[1]), 2);
    chk("order_2", 32'(rec[2]), 3);
    chk("order_3", 32'(rec[3]), 0);
    chk("order_4", 32'(rec[4]), 1);
    wait_idle("order_idle_timeout");

    // game_active dropped during HOLD with 2 queued
    btn_jump = 1; tick(); btn_jump = 0;
    btn_slide = 1; tick(); btn_slide = 0;
    chk("ga_issue", 32'(act_valid), 1);
    btn_left = 1; tick(); btn_left = 0;
    chk("ga_hold_busy", 32'(busy), 1);
    chk("ga_hold_valid", 32'(act_valid), 0);
    chk("ga_count2", 32'(fifo_count), 2);
    game_active = 1'b0;
    tick();
    chk("ga_count0", 32'(fifo_count), 0);
    chk("ga_busy0", 32'(busy), 0);
    chk("ga_valid0", 32'(act_valid), 0);
    btn_jump = 1; btn_left = 1; tick(); btn_jump = 0; btn_left = 0;
    chk("ga_ign_count", 32'(fifo_count), 0);
    chk("ga_ign_drop", 32'(dropped), 0);
    tick();
    chk("ga_ign_drop2", 32'(dropped), 0);
    game_active = 1'b1;
    valid_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (act_valid || busy) valid_seen = 1'b1;
    end
    chk("ga_no_issue", 32'(valid_seen), 0);

    // Reset during COOL with 3 queued
    btn_left = 1; tick(); btn_left = 0;
    tick();
    chk("rc_issue", 32'(act_valid), 1);
    btn_jump = 1; tick(); btn_jump = 0;
    btn_slide = 1; tick(); btn_slide = 0;
    btn_right = 1; tick(); btn_right = 0;
    chk("rc_count3", 32'(fifo_count), 3);
    chk("rc_busy", 32'(busy), 1);
    reset = 1'b0;
    tick();
    chk("rc_valid", 32'(act_valid), 0);
    chk("rc_code", 32'(act_code), 0);
    chk("rc_busy0", 32'(busy), 0);
    chk("rc_count0", 32'(fifo_count), 0);
    chk("rc_drop", 32'(dropped), 0);
    reset = 1'b1;
    valid_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (act_valid || busy || fifo_count != 0) valid_seen = 1'b1;
    end
    chk("rc_no_issue", 32'(valid_seen), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
